// File: rtl/bus_arbiter.sv
// Round-robin arbiter that shares one single-port RAM among N_CLIENTS
// request/ack clients. It drives the RAM handshake, drops mem_rq for one
// cycle between transactions, and returns read data to the winning client.
module bus_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_CLIENTS-1:0]             clt_rq,
    input  logic [N_CLIENTS-1:0]             clt_wr_ni,
    input  logic [N_CLIENTS*ADDR_WIDTH-1:0]  clt_address,
    input  logic [N_CLIENTS*DATA_WIDTH-1:0]  clt_dataW,
    output logic [N_CLIENTS-1:0]             clt_ack,
    output logic [DATA_WIDTH-1:0]            clt_dataR,
    output logic [N_CLIENTS-1:0]             grant,
    output logic                             mem_rq,
    output logic                             mem_wr_ni,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic [DATA_WIDTH-1:0]            mem_dataW,
    input  logic                             mem_ack,
    input  logic [DATA_WIDTH-1:0]            mem_dataR
);

    localparam int PW = $clog2(N_CLIENTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [PW-1:0]           r_ptr, w_ptr_nxt;
    logic [N_CLIENTS-1:0]    r_grant, w_grant_nxt;
    logic [N_CLIENTS-1:0]    r_ack, w_ack_nxt;
    logic [DATA_WIDTH-1:0]   r_dataR, w_dataR_nxt;
    logic                    r_mem_rq, w_mem_rq_nxt;
    logic                    r_mem_wr_ni, w_mem_wr_ni_nxt;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem_dataW, w_mem_dataW_nxt;

    logic [N_CLIENTS-1:0]    w_req;
    logic [PW:0]             w_arb;
    logic                    w_found;
    logic [PW-1:0]           w_win;
    logic [PW-1:0]           w_win_inc;
    logic [N_CLIENTS-1:0]    w_win_oh;

    // First set bit of req at or after ptr, wrapping; MSB of result = found.
    function automatic logic [PW:0] f_arb(input logic [N_CLIENTS-1:0] req,
                                          input logic [PW-1:0]        ptr);
        logic [PW:0] res;
        int          j;
        res = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            j = int'(ptr) + k;
            if (j >= N_CLIENTS) j = j - N_CLIENTS;
            if (!res[PW] && req[j]) res = {1'b1, PW'(j)};
        end
        return res;
    endfunction

    // In DONE the just-served client still shows rq, so it is masked out.
    assign w_req     = (r_state == DONE) ? (clt_rq & ~r_grant) : clt_rq;
    assign w_arb     = f_arb(w_req, r_ptr);
    assign w_found   = w_arb[PW];
    assign w_win     = w_arb[PW-1:0];
    assign w_win_inc = (w_win == PW'(N_CLIENTS - 1)) ? '0 : w_win + 1'b1;
    assign w_win_oh  = {{(N_CLIENTS-1){1'b0}}, 1'b1} << w_win;

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_nxt     = r_grant;
        w_ack_nxt       = '0;
        w_dataR_nxt     = r_dataR;
        w_mem_rq_nxt    = r_mem_rq;
        w_mem_wr_ni_nxt = r_mem_wr_ni;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_dataW_nxt = r_mem_dataW;
        case (r_state)
            IDLE, DONE: begin
                if (w_found) begin
                    w_state_nxt     = BUSY;
                    w_ptr_nxt       = w_win_inc;
                    w_grant_nxt     = w_win_oh;
                    w_mem_rq_nxt    = 1'b1;
                    w_mem_wr_ni_nxt = clt_wr_ni[w_win];
                    w_mem_addr_nxt  = clt_address[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                    w_mem_dataW_nxt = clt_dataW[w_win*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_mem_rq_nxt = 1'b0;
                end
            end
            BUSY: begin
                // Client rq is ignored here: a started transaction always completes.
                if (mem_ack) begin
                    w_state_nxt  = DONE;
                    w_dataR_nxt  = mem_dataR;
                    w_ack_nxt    = r_grant;
                    w_mem_rq_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_grant_nxt  = '0;
                w_mem_rq_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_dataR     <= '0;
            r_mem_rq    <= 1'b0;
            r_mem_wr_ni <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_dataW <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_grant     <= w_grant_nxt;
            r_ack       <= w_ack_nxt;
            r_dataR     <= w_dataR_nxt;
            r_mem_rq    <= w_mem_rq_nxt;
            r_mem_wr_ni <= w_mem_wr_ni_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_dataW <= w_mem_dataW_nxt;
        end
    end

    assign clt_ack     = r_ack;
    assign clt_dataR   = r_dataR;
    assign grant       = r_grant;
    assign mem_rq      = r_mem_rq;
    assign mem_wr_ni   = r_mem_wr_ni;
    assign mem_address = r_mem_addr;
    assign mem_dataW   = r_mem_dataW;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a small two-cycle RAM model.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    clt_rq = '0;
    logic [N-1:0]    clt_wr_ni = '0;
    logic [N*AW-1:0] clt_address = '0;
    logic [N*DW-1:0] clt_dataW = '0;
    logic [N-1:0]    clt_ack;
    logic [DW-1:0]   clt_dataR;
    logic [N-1:0]    grant;
    logic            mem_rq, mem_wr_ni;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_dataW;
    logic            mem_ack;
    logic [DW-1:0]   mem_dataR;

    logic [DW-1:0]   ram [0:(1<<AW)-1];
    logic            rq_d;
    logic            force_ack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Contention expectations for cycles 1..10
    localparam logic [3:0] CT_G [10] = '{4'h1,4'h1,4'h1,4'h4,4'h4,4'h4,4'h8,4'h8,4'h8,4'h0};
    localparam logic [3:0] CT_K [10] = '{4'h0,4'h0,4'h1,4'h0,4'h0,4'h4,4'h0,4'h0,4'h8,4'h0};
    localparam logic       CT_M [10] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0};
    localparam logic [3:0] CT_A [3]  = '{4'h5,4'h6,4'h7};
    // Fairness read addresses and the data each holds
    localparam logic [3:0] FA [4] = '{4'h5,4'h3,4'h6,4'h7};
    localparam logic [7:0] FD [4] = '{8'h50,8'hA5,8'h62,8'h73};

    always #5 clk = ~clk;

    bus_arbiter #(.N_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .clt_rq(clt_rq), .clt_wr_ni(clt_wr_ni), .clt_address(clt_address), .clt_dataW(clt_dataW),
        .clt_ack(clt_ack), .clt_dataR(clt_dataR), .grant(grant),
        .mem_rq(mem_rq), .mem_wr_ni(mem_wr_ni), .mem_address(mem_address), .mem_dataW(mem_dataW),
        .mem_ack(mem_ack), .mem_dataR(mem_dataR)
    );

    // RAM: ack in the 2nd consecutive rq cycle, registered read data
    assign mem_ack = (mem_rq & rq_d) | force_ack;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_d      <= 1'b0;
            mem_dataR <= '0;
        end else begin
            rq_d <= mem_rq;
            if (mem_rq) begin
                if (!mem_wr_ni) ram[mem_address] <= mem_dataW;
                mem_dataR <= ram[mem_address];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_clt(input int i, input logic rq, input logic wr_ni,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        clt_rq[i]             = rq;
        clt_wr_ni[i]          = wr_ni;
        clt_address[i*AW +: AW] = a;
        clt_dataW[i*DW +: DW]   = d;
    endtask

    task automatic test_reset();
        logic [N-1:0] ack_or, gnt_or;
        rst_n = 1'b0;
        step(); step();
        n_checks++; if (grant !== 4'h0) begin n_errors++; $display("FAIL rst_grant: got %h exp 0", grant); end
        n_checks++; if (mem_rq !== 1'b0) begin n_errors++; $display("FAIL rst_mem_rq: got %b exp 0", mem_rq); end
        n_checks++; if (clt_ack !== 4'h0) begin n_errors++; $display("FAIL rst_ack: got %h exp 0", clt_ack); end
        n_checks++; if ({mem_wr_ni, mem_address, mem_dataW, clt_dataR} !== '0) begin
            n_errors++; $display("FAIL rst_outs: got %b/%h/%h/%h exp 0", mem_wr_ni, mem_address, mem_dataW, clt_dataR); end
        rst_n = 1'b1;
        step();
        // start a write, then pull reset while it is in flight
        set_clt(0, 1'b1, 1'b0, 4'h2, 8'h22);
        step();
        n_checks++; if (mem_rq !== 1'b1 || grant !== 4'h1) begin
            n_errors++; $display("FAIL abort_start: got rq=%b grant=%h exp rq=1 grant=1", mem_rq, grant); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (mem_rq !== 1'b0) begin n_errors++; $display("FAIL abort_mem_rq: got %b exp 0", mem_rq); end
        n_checks++; if (grant !== 4'h0) begin n_errors++; $display("FAIL abort_grant: got %h exp 0", grant); end
        n_checks++; if (clt_ack !== 4'h0) begin n_errors++; $display("FAIL abort_ack: got %h exp 0", clt_ack); end
        set_clt(0, 1'b0, 1'b0, 4'h0, 8'h00);
        step(); step();
        rst_n = 1'b1;
        ack_or = '0; gnt_or = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            ack_or |= clt_ack;
            gnt_or |= grant;
        end
        n_checks++; if (ack_or !== 4'h0 || gnt_or !== 4'h0) begin
            n_errors++; $display("FAIL abort_no_ack: got ack=%h grant=%h exp 0/0", ack_or, gnt_or); end
    endtask

    task automatic test_write_read();
        set_clt(1, 1'b1, 1'b0, 4'h3, 8'hA5);
        step(); // c1
        n_checks++; if (grant !== 4'h2 || mem_rq !== 1'b1) begin
            n_errors++; $display("FAIL wr_c1: got grant=%h rq=%b exp 2/1", grant, mem_rq); end
        n_checks++; if (mem_wr_ni !== 1'b0 || mem_address !== 4'h3 || mem_dataW !== 8'hA5) begin
            n_errors++; $display("FAIL wr_fields: got %b/%h/%h exp 0/3/a5", mem_wr_ni, mem_address, mem_dataW); end
        step(); // c2
        n_checks++; if (clt_ack !== 4'h0 || mem_rq !== 1'b1) begin
            n_errors++; $display("FAIL wr_c2: got ack=%h rq=%b exp 0/1", clt_ack, mem_rq); end
        step(); // c3
        n_checks++; if (clt_ack !== 4'h2 || mem_rq !== 1'b0) begin
            n_errors++; $display("FAIL wr_ack: got ack=%h rq=%b exp 2/0", clt_ack, mem_rq); end
        step(); // c4: back in IDLE, client issues the read
        n_checks++; if (clt_ack !== 4'h0 || grant !== 4'h0 || mem_rq !== 1'b0) begin
            n_errors++; $display("FAIL wr_c4: got ack=%h grant=%h rq=%b exp 0/0/0", clt_ack, grant, mem_rq); end
        set_clt(1, 1'b1, 1'b1, 4'h3, 8'h00);
        step(); // c5
        n_checks++; if (mem_rq !== 1'b1 || mem_wr_ni !== 1'b1 || mem_address !== 4'h3) begin
            n_errors++; $display("FAIL rd_c5: got rq=%b wr_ni=%b addr=%h exp 1/1/3", mem_rq, mem_wr_ni, mem_address); end
        step(); step(); // c7
        n_checks++; if (clt_ack !== 4'h2) begin n_errors++; $display("FAIL rd_ack: got %h exp 2", clt_ack); end
        n_checks++; if (clt_dataR !== 8'hA5) begin n_errors++; $display("FAIL rd_data: got %h exp a5", clt_dataR); end
        step();
        set_clt(1, 1'b0, 1'b0, 4'h0, 8'h00);
        step(); step();
    endtask

    task automatic test_contention();
        logic [N-1:0] prev_ack;
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        set_clt(0, 1'b1, 1'b0, 4'h5, 8'h50);
        set_clt(2, 1'b1, 1'b0, 4'h6, 8'h62);
        set_clt(3, 1'b1, 1'b0, 4'h7, 8'h73);
        prev_ack = '0;
        for (int c = 1; c <= 10; c++) begin
            step();
            clt_rq = clt_rq & ~prev_ack;
            prev_ack = clt_ack;
            n_checks++; if (grant !== CT_G[c-1] || !$onehot0(grant)) begin
                n_errors++; $display("FAIL ct_grant c%0d: got %h exp %h", c, grant, CT_G[c-1]); end
            n_checks++; if (clt_ack !== CT_K[c-1]) begin
                n_errors++; $display("FAIL ct_ack c%0d: got %h exp %h", c, clt_ack, CT_K[c-1]); end
            n_checks++; if (mem_rq !== CT_M[c-1]) begin
                n_errors++; $display("FAIL ct_mem_rq c%0d: got %b exp %b", c, mem_rq, CT_M[c-1]); end
            if (c % 3 == 1 && c < 10) begin
                n_checks++; if (mem_address !== CT_A[c/3]) begin
                    n_errors++; $display("FAIL ct_addr c%0d: got %h exp %h", c, mem_address, CT_A[c/3]); end
            end
        end
        clt_rq = '0;
        step();
    endtask

    task automatic test_fairness();
        logic [N-1:0] prev_ack, prev_drop;
        logic [N-1:0] eg, ek;
        int o;
        for (int i = 0; i < N; i++) set_clt(i, 1'b1, 1'b1, FA[i], 8'h00);
        prev_ack = '0; prev_drop = '0;
        for (int c = 1; c <= 24; c++) begin
            step();
            clt_rq    = (clt_rq & ~prev_ack) | prev_drop;
            prev_drop = prev_ack;
            prev_ack  = clt_ack;
            o  = ((c - 1) / 3) % 4;
            eg = 4'h1 << o;
            ek = (c % 3 == 0) ? eg : 4'h0;
            n_checks++; if (grant !== eg) begin
                n_errors++; $display("FAIL rr_grant c%0d: got %h exp %h", c, grant, eg); end
            n_checks++; if (clt_ack !== ek) begin
                n_errors++; $display("FAIL rr_ack c%0d: got %h exp %h", c, clt_ack, ek); end
            if (c % 3 == 0) begin
                n_checks++; if (clt_dataR !== FD[o]) begin
                    n_errors++; $display("FAIL rr_data c%0d: got %h exp %h", c, clt_dataR, FD[o]); end
            end
        end
        clt_rq = '0;
        step();
        n_checks++; if (grant !== 4'h0 || mem_rq !== 1'b0) begin
            n_errors++; $display("FAIL rr_idle: got grant=%h rq=%b exp 0/0", grant, mem_rq); end
        step();
    endtask

    task automatic test_persistent();
        set_clt(2, 1'b1, 1'b1, 4'h6, 8'h00);
        step(); // c1
        n_checks++; if (grant !== 4'h4) begin n_errors++; $display("FAIL ps_grant1: got %h exp 4", grant); end
        step(); step(); // c3
        n_checks++; if (clt_ack !== 4'h4 || clt_dataR !== 8'h62) begin
            n_errors++; $display("FAIL ps_ack1: got ack=%h data=%h exp 4/62", clt_ack, clt_dataR); end
        step(); // c4
        n_checks++; if (grant !== 4'h0 || mem_rq !== 1'b0) begin
            n_errors++; $display("FAIL ps_no_regrant: got grant=%h rq=%b exp 0/0", grant, mem_rq); end
        set_clt(2, 1'b1, 1'b1, 4'h7, 8'h00);
        step(); // c5
        n_checks++; if (grant !== 4'h4 || mem_rq !== 1'b1 || mem_address !== 4'h7) begin
            n_errors++; $display("FAIL ps_grant2: got grant=%h rq=%b addr=%h exp 4/1/7", grant, mem_rq, mem_address); end
        step(); // c6
        n_checks++; if (clt_ack !== 4'h0) begin n_errors++; $display("FAIL ps_c6: got %h exp 0", clt_ack); end
        step(); // c7
        n_checks++; if (clt_ack !== 4'h4 || clt_dataR !== 8'h73) begin
            n_errors++; $display("FAIL ps_ack2: got ack=%h data=%h exp 4/73", clt_ack, clt_dataR); end
        step();
        set_clt(2, 1'b0, 1'b0, 4'h0, 8'h00);
        step(); step();
    endtask

    task automatic test_req_drop();
        int acks, other;
        logic [N-1:0] gnt_or;
        set_clt(0, 1'b1, 1'b0, 4'h9, 8'h99);
        step(); // c1
        n_checks++; if (grant !== 4'h1 || mem_rq !== 1'b1) begin
            n_errors++; $display("FAIL dr_start: got grant=%h rq=%b exp 1/1", grant, mem_rq); end
        set_clt(0, 1'b0, 1'b0, 4'h9, 8'h99);
        step(); // c2
        n_checks++; if (grant !== 4'h1 || mem_rq !== 1'b1) begin
            n_errors++; $display("FAIL dr_hold: got grant=%h rq=%b exp 1/1", grant, mem_rq); end
        acks = 0; other = 0; gnt_or = '0;
        for (int c = 3; c <= 8; c++) begin
            step();
            if (clt_ack[0]) acks++;
            if (clt_ack[N-1:1] != '0) other++;
            if (c == 3) begin
                n_checks++; if (clt_ack !== 4'h1) begin n_errors++; $display("FAIL dr_ack: got %h exp 1", clt_ack); end
            end else begin
                gnt_or |= grant;
            end
        end
        n_checks++; if (acks != 1 || other != 0) begin
            n_errors++; $display("FAIL dr_ack_count: got %0d/%0d exp 1/0", acks, other); end
        n_checks++; if (gnt_or !== 4'h0) begin n_errors++; $display("FAIL dr_no_regrant: got %h exp 0", gnt_or); end
    endtask

    task automatic test_stray_ack();
        force_ack = 1'b1;
        step(); step(); step();
        n_checks++; if (clt_ack !== 4'h0 || grant !== 4'h0 || mem_rq !== 1'b0) begin
            n_errors++; $display("FAIL stray_ack: got ack=%h grant=%h rq=%b exp 0/0/0", clt_ack, grant, mem_rq); end
        force_ack = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_fairness();
        test_persistent();
        test_req_drop();
        test_stray_ack();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sharing one single-port RAM among N clients.
- Each client has its own rq/ack request interface. The arbiter sequences the RAM's rq/ack handshake, including the mandatory rq drop between transactions, and routes read data back to the winning client.
- Sits between client masters and the RAM instance in the bus subsystem.

Parameters:
- N_CLIENTS, 4, number of requesting clients (2..8).
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clt_rq  in  N_CLIENTS  per-client request level.
- clt_wr_ni  in  N_CLIENTS  per-client op select: 1 = read, 0 = write.
- clt_address  in  N_CLIENTS*ADDR_WIDTH  packed addresses; client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- clt_dataW  in  N_CLIENTS*DATA_WIDTH  packed write data; same packing.
- clt_ack  out  N_CLIENTS  one-cycle completion pulse, at most one bit set.
- clt_dataR  out  DATA_WIDTH  read data; valid in the cycle clt_ack is high.
- grant  out  N_CLIENTS  one-hot current owner; 0 when idle.
- mem_rq  out  1  RAM request.
- mem_wr_ni  out  1  RAM op select.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_dataW  out  DATA_WIDTH  RAM write data.
- mem_ack  in  1  RAM acknowledge. RAM asserts it in the 2nd consecutive cycle of rq high.
- mem_dataR  in  DATA_WIDTH  RAM read data, registered by the RAM.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; round-robin pointer ptr = 0.
  - Reset mid-transaction aborts immediately; no ack is issued for the aborted op.
- All outputs are registered.
- Client protocol:
  - A client holds clt_rq, wr_ni, address and dataW stable until it sees its clt_ack pulse.
  - It drops clt_rq in the cycle after the ack.
- Arbitration:
  - Search clt_rq starting at index ptr, ascending, wrapping modulo N_CLIENTS; the first set bit wins.
  - On grant to client g: ptr <= (g+1) mod N_CLIENTS.
- State IDLE:
  - If any clt_rq is set: latch winner's wr_ni/address/dataW onto mem_*, set grant, mem_rq <= 1, go to BUSY.
  - Otherwise stay in IDLE.
- State BUSY:
  - Hold mem_rq and mem_* stable.
  - When mem_ack = 1: capture mem_dataR into clt_dataR (writes capture it too; value don't-care), pulse clt_ack[g] <= 1, mem_rq <= 0, go to DONE.
- State DONE (mem_rq low for exactly one cycle, which clears the RAM's rq_d):
  - clt_ack clears next cycle.
  - Arbitrate over clt_rq with bit g masked, since that client still shows rq this cycle.
  - If a winner exists: grant it and go straight to BUSY with mem_rq <= 1. Otherwise grant <= 0 and go to IDLE.
- Timing:
  - clt_rq sampled in cycle 0 → mem_rq high in cycles 1–2 → mem_ack high in cycle 2 → clt_ack and clt_dataR in cycle 3.
  - Back-to-back throughput: one transaction per 3 cycles.
- Client drops clt_rq while granted: the transaction completes anyway and the ack is still pulsed.
- mem_ack seen outside BUSY: ignored.
- Starvation: bounded; any requester is served within N_CLIENTS transactions.

Test Plan:
- Reset then idle: rst_n low mid-BUSY → mem_rq = 0, grant = 0, clt_ack = 0 immediately, asynchronously; after release no ack for the aborted op.
- Single write then read: client 1 writes 8'hA5 to addr 3, then reads addr 3 → clt_ack[1] in cycle 3 of each op; read returns clt_dataR = 8'hA5; mem_rq low one cycle between ops.
- Contention: clients 0, 2, 3 request together from reset → service order 0, 2, 3; each ack 3 cycles apart; grant one-hot throughout.
- Wrap-around fairness: all 4 clients hold requests continuously, re-asserting after each ack → grant order 0,1,2,3,0,1…; no client waits more than 4 transactions.
- Single persistent requester: client 2 issues two consecutive reads → DONE does not re-grant it spuriously; second grant starts from IDLE, with ack spacing 4 cycles.
- Request drop: client 0 drops clt_rq while in BUSY → transaction still completes and clt_ack[0] pulses once; no extra grant to client 0.
